signed_blk_avg: RTL and testbench



---
 rtl/signed_dsp_pkg.sv | 33 +++
 rtl/signed_rnd_sat.sv | 35 +++
 rtl/signed_blk_avg.sv | 95 +++++++++
 tb/tb_signed_blk_avg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/signed_dsp_pkg.sv
// Shared constants and helpers for the signed sample datapath.
// sat_s is used by any stage that narrows a signed value.
package signed_dsp_pkg;

  localparam int DIN_W_DEF  = 9;
  localparam int DOUT_W_DEF = 8;

  typedef struct packed {
    logic signed [31:0] val;
    logic               ovf;
  } sat_res_t;

  // Clamp value into a signed range of 'width' bits (width 2..31).
  function automatic sat_res_t sat_s(input logic signed [31:0] value,
                                     input int unsigned        width);
    sat_res_t           res;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    res.val = value;
    res.ovf = 1'b0;
    if (value > hi) begin
      res.val = hi;
      res.ovf = 1'b1;
    end else if (value < lo) begin
      res.val = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/signed_rnd_sat.sv
// Divides a block sum by 2^LOG2N with round-half-up, then clamps to DOUT_W.
// Purely combinational; the caller registers the outputs.
module signed_rnd_sat
  import signed_dsp_pkg::*;
#(
  parameter int LOG2N  = 3,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int ACC_W  = DIN_W_DEF + LOG2N
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     ovf
);

  localparam int BIAS_I = 1 << (LOG2N - 1);

  logic signed [ACC_W-1:0] bias;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] rnd;
  logic signed [31:0]      rnd_ext;
  sat_res_t                res;
  logic                    unused_hi;

  // The bias add cannot overflow: a full block of max samples leaves
  // N counts of headroom below the accumulator ceiling.
  assign bias      = ACC_W'(BIAS_I);
  assign biased    = sum + bias;
  assign rnd       = biased >>> LOG2N;
  assign rnd_ext   = {{(32 - ACC_W){rnd[ACC_W-1]}}, rnd};
  assign res       = sat_s(rnd_ext, DOUT_W);
  assign dout      = res.val[DOUT_W-1:0];
  assign ovf       = res.ovf;
  assign unused_hi = ^res.val[31:DOUT_W];

endmodule

// File: rtl/signed_blk_avg.sv
// Block averager: sums 2^LOG2N valid signed samples and emits the rounded,
// saturated mean as a one-cycle pulse; clr flushes the partial block.
module signed_blk_avg
  import signed_dsp_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int LOG2N  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DIN_W-1:0]  din,
  input  logic                     din_vld,
  input  logic                     clr,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_vld,
  output logic                     ovf,
  output logic [LOG2N-1:0]         blk_cnt
);

  localparam int ACC_W = DIN_W + LOG2N;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2N-1:0]         cnt_q, cnt_d;
  logic signed [DOUT_W-1:0] dout_q, dout_d;
  logic                     dout_vld_q, dout_vld_d;
  logic                     ovf_q, ovf_d;

  logic signed [ACC_W-1:0]  din_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [DOUT_W-1:0] rs_dout;
  logic                     rs_ovf;
  logic                     final_smp;

  assign din_ext   = {{LOG2N{din[DIN_W-1]}}, din};
  assign sum       = acc_q + din_ext;
  assign final_smp = &cnt_q;

  signed_rnd_sat #(
    .LOG2N  (LOG2N),
    .DOUT_W (DOUT_W),
    .ACC_W  (ACC_W)
  ) u_rnd_sat (
    .sum  (sum),
    .dout (rs_dout),
    .ovf  (rs_ovf)
  );

  // din only reaches state through the accept branch, so X on an idle
  // cycle never lands in the accumulator.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    ovf_d      = 1'b0;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (din_vld) begin
      if (final_smp) begin
        acc_d      = '0;
        cnt_d      = '0;
        dout_d     = rs_dout;
        ovf_d      = rs_ovf;
        dout_vld_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + LOG2N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign ovf      = ovf_q;
  assign blk_cnt  = cnt_q;

endmodule

// File: tb/tb_signed_blk_avg.sv
// Scoreboard bench for signed_blk_avg: the driver queues hand-computed
// results as each block completes; a negedge monitor pops and compares.
module tb_signed_blk_avg;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [8:0] din = '0;
  logic              din_vld = 1'b0;
  logic              clr = 1'b0;
  logic signed [7:0] dout;
  logic              dout_vld;
  logic              ovf;
  logic [2:0]        blk_cnt;

  typedef struct {
    int d;
    int o;
    int c;
  } exp_t;
  typedef int vec8_t[8];

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   p0;

  signed_blk_avg #(.DIN_W(9), .DOUT_W(8), .LOG2N(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .clr      (clr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .ovf      (ovf),
    .blk_cnt  (blk_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_vld) begin
      exp_t e;
      pulses++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got dout=%0d with no result pending", $signed(dout));
      end else begin
        e = q.pop_front();
        chk("dout", int'($signed(dout)), e.d);
        chk("ovf", int'(ovf), e.o);
        chk("latency_cycle", cyc, e.c);
      end
    end
  end

  task automatic step(input logic v, input logic signed [8:0] d, input logic c);
    din_vld = v;
    din     = d;
    clr     = c;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    din     = 'x;
    clr     = 1'b0;
  endtask

  task automatic blk(input vec8_t v, input int e_d, input int e_o, input int maxgap);
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) step(1'b0, 'x, 1'b0);
      step(1'b1, 9'(v[i]), 1'b0);
      chk("blk_cnt", int'(blk_cnt), (i + 1) % 8);
      if (i == 7) q.push_back('{e_d, e_o, cyc});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_dout", int'($signed(dout)), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_blk_cnt", int'(blk_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 'x, 1'b0);

    // Plain block, then a clr right after the final sample
    blk('{10, 10, 10, 10, 10, 10, 10, 10}, 10, 0, 0);
    step(1'b0, 'x, 1'b1);
    chk("blk_cnt_after_clr", int'(blk_cnt), 0);

    // Saturation both ways
    blk('{255, 255, 255, 255, 255, 255, 255, 255}, 127, 1, 0);
    blk('{-256, -256, -256, -256, -256, -256, -256, -256}, -128, 1, 0);

    // Rounding
    blk('{1, 1, 1, 1, 0, 0, 0, 0}, 1, 0, 0);
    blk('{-1, -1, -1, -1, 0, 0, 0, 0}, 0, 0, 0);
    blk('{-1, -1, -1, -1, -1, 0, 0, 0}, -1, 0, 0);
    blk('{1, 1, 1, 0, 0, 0, 0, 0}, 0, 0, 0);

    // Same data with random idle gaps
    step(1'b0, 'x, 1'b0);
    p0 = pulses;
    blk('{10, 10, 10, 10, 10, 10, 10, 10}, 10, 0, 5);
    blk('{255, 255, 255, 255, 255, 255, 255, 255}, 127, 1, 5);
    blk('{-1, -1, -1, -1, -1, 0, 0, 0}, -1, 0, 5);
    step(1'b0, 'x, 1'b0);
    chk("gap_pulses", pulses - p0, 3);

    // clr collides with a valid sample: sample dropped, partial block gone
    repeat (5) step(1'b1, 9'sd50, 1'b0);
    chk("blk_cnt_partial", int'(blk_cnt), 5);
    step(1'b1, 9'sd99, 1'b1);
    chk("blk_cnt_clr", int'(blk_cnt), 0);
    blk('{3, 3, 3, 3, 3, 3, 3, 3}, 3, 0, 0);

    // Reset mid-block instead of clr
    repeat (5) step(1'b1, 9'sd50, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", int'($signed(dout)), 0);
    chk("midrst_vld", int'(dout_vld), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_blk_cnt", int'(blk_cnt), 0);
    step(1'b1, 9'sd50, 1'b0);
    chk("midrst_hold_blk_cnt", int'(blk_cnt), 0);
    rst_n = 1'b1;
    blk('{3, 3, 3, 3, 3, 3, 3, 3}, 3, 0, 0);

    // Back-to-back blocks, no dead cycle
    blk('{-7, -7, -7, -7, -7, -7, -7, -7}, -7, 0, 0);
    blk('{-7, -7, -7, -7, -7, -7, -7, -7}, -7, 0, 0);
    repeat (3) step(1'b0, 'x, 1'b0);
    chk("dout_hold", int'($signed(dout)), -7);
    chk("vld_low", int'(dout_vld), 0);

    chk("queue_empty", q.size(), 0);
    chk("total_pulses", pulses, 14);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
